// File: rtl/fir_mac_sequencer_if.sv
// Bus bundle for the FIR MAC sequencer: sample strobe, host coefficient-write
// handshake, and the control outputs that steer the MAC datapath.
// Handshake: the host raises iCoefWrReq with address/data and holds them
// stable until it sees the one-cycle oCoefWrAck pulse. It then drops the
// request during that ack cycle. A write is granted only while the sequencer
// is idle and no sample strobe is present.
interface fir_mac_sequencer_if #(
    parameter int IDX_W  = 4,
    parameter int COEF_W = 8
);
    logic                     iEnSample600k;
    logic                     iCoefWrReq;
    logic [IDX_W-1:0]         iCoefWrAddr;
    logic signed [COEF_W-1:0] iCoefWrData;
    logic                     oCoefWrAck;
    logic                     oCoefWe;
    logic [IDX_W-1:0]         oCoefWrAddr;
    logic signed [COEF_W-1:0] oCoefWrData;
    logic                     oCoefRdEn;
    logic [IDX_W-1:0]         oTapSel;
    logic                     oCenter;
    logic                     oAccClr;
    logic                     oAccEn;
    logic                     oOutValid;
    logic                     oBusy;
    logic                     oOverrun;
    logic [1:0]               oDbgState;

    // Host / testbench side.
    modport master (
        output iEnSample600k, iCoefWrReq, iCoefWrAddr, iCoefWrData,
        input  oCoefWrAck, oCoefWe, oCoefWrAddr, oCoefWrData, oCoefRdEn,
        input  oTapSel, oCenter, oAccClr, oAccEn, oOutValid, oBusy, oOverrun,
        input  oDbgState
    );

    // Sequencer side.
    modport slave (
        input  iEnSample600k, iCoefWrReq, iCoefWrAddr, iCoefWrData,
        output oCoefWrAck, oCoefWe, oCoefWrAddr, oCoefWrData, oCoefRdEn,
        output oTapSel, oCenter, oAccClr, oAccEn, oOutValid, oBusy, oOverrun,
        output oDbgState
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Control FSM for the time-multiplexed symmetric FIR MAC.
// On each sample strobe the FSM clears the accumulator. It then walks the
// folded tap pairs, one per clock, and finally flags the finished sum.
// Host coefficient writes are admitted only while the FSM is idle.
// All outputs are registered.
module fir_mac_sequencer #(
    parameter int NUM_TAPS = 21,
    parameter int IDX_W    = 4,
    parameter int COEF_W   = 8
) (
    input  logic                  iClk12M,
    input  logic                  iRsn,
    fir_mac_sequencer_if.slave    bus
);
    localparam int NUM_PAIRS = (NUM_TAPS + 1) / 2;
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_PAIRS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    logic                     r_acc_clr;
    logic                     r_acc_en;
    logic                     r_rd_en;
    logic [IDX_W-1:0]         r_tap_sel;
    logic                     r_center;
    logic                     r_out_valid;
    logic                     r_busy;
    logic                     r_overrun;
    logic                     r_wr_ack;
    logic                     r_coef_we;
    logic [IDX_W-1:0]         r_wr_addr;
    logic signed [COEF_W-1:0] r_wr_data;

    logic w_grant;
    logic w_addr_ok;

    // A write is granted only in a quiet idle cycle. The strobe has priority.
    // The !r_wr_ack term spaces writes so that a request still held in its
    // ack cycle cannot be granted twice.
    assign w_grant   = bus.iCoefWrReq && (r_state == S_IDLE) &&
                       !bus.iEnSample600k && !r_wr_ack;
    // Addresses beyond the last pair are acknowledged but not written.
    assign w_addr_ok = ({1'b0, bus.iCoefWrAddr} < (IDX_W+1)'(NUM_PAIRS));

    // Sequencer FSM, overrun flag and write arbitration; r_tap_sel doubles as pair counter.
    always_ff @(posedge iClk12M) begin
        if (!iRsn) begin
            r_state     <= S_IDLE;
            r_acc_clr   <= 1'b0;
            r_acc_en    <= 1'b0;
            r_rd_en     <= 1'b0;
            r_tap_sel   <= '0;
            r_center    <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_coef_we   <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_acc_clr   <= 1'b0;
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.iEnSample600k) begin
                        r_state   <= S_CLEAR;
                        r_acc_clr <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state   <= S_RUN;
                    r_tap_sel <= '0;
                    r_center  <= (LAST_K == '0);
                    r_acc_en  <= 1'b1;
                    r_rd_en   <= 1'b1;
                end
                S_RUN: begin
                    if (r_tap_sel == LAST_K) begin
                        // tap select keeps its last value after the run
                        r_state     <= S_DONE;
                        r_acc_en    <= 1'b0;
                        r_rd_en     <= 1'b0;
                        r_center    <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_tap_sel <= r_tap_sel + 1'b1;
                        r_center  <= ((r_tap_sel + 1'b1) == LAST_K);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase

            if (bus.iEnSample600k && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            r_wr_ack  <= w_grant;
            r_coef_we <= w_grant && w_addr_ok;
            if (w_grant) begin
                r_wr_addr <= bus.iCoefWrAddr;
                r_wr_data <= bus.iCoefWrData;
            end
        end
    end

    assign bus.oAccClr     = r_acc_clr;
    assign bus.oAccEn      = r_acc_en;
    assign bus.oCoefRdEn   = r_rd_en;
    assign bus.oTapSel     = r_tap_sel;
    assign bus.oCenter     = r_center;
    assign bus.oOutValid   = r_out_valid;
    assign bus.oBusy       = r_busy;
    assign bus.oOverrun    = r_overrun;
    assign bus.oCoefWrAck  = r_wr_ack;
    assign bus.oCoefWe     = r_coef_we;
    assign bus.oCoefWrAddr = r_wr_addr;
    assign bus.oCoefWrData = r_wr_data;
    assign bus.oDbgState   = r_state;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Testbench for fir_mac_sequencer. The reference model turns every accepted
// strobe and granted write into time-stamped expected events, using the
// sequence timing rules. A monitor compares the DUT against those events
// every clock.
module tb_fir_mac_sequencer;
    localparam int NUM_PAIRS = 11;
    localparam int INF = 32'h7fff_ffff;

    typedef struct { int obs; logic [3:0] tap; logic center; } tap_ev_t;
    typedef struct { int obs; logic we; logic [3:0] addr; logic [7:0] data; } wr_ev_t;

    logic clk = 1'b0;
    logic rsn = 1'b0;
    int   cyc = -1;

    fir_mac_sequencer_if #(.IDX_W(4), .COEF_W(8)) bus ();

    fir_mac_sequencer #(.NUM_TAPS(21), .IDX_W(4), .COEF_W(8)) dut (
        .iClk12M (clk),
        .iRsn    (rsn),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- scoreboard state ----------------
    int      clr_q[$];
    int      out_q[$];
    tap_ev_t tap_q[$];
    wr_ev_t  wr_q[$];
    int      idle_from    = 0;
    int      overrun_from = INF;
    int      last_grant   = -10;
    int      rst_obs      = -1;
    bit      seen_rst     = 0;
    int      n_cmp = 0;
    int      n_err = 0;

    logic       h_req  = 1'b0;
    logic [3:0] h_addr = '0;
    logic [7:0] h_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @obs %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: what edge E does, given the inputs presented at that edge.
    task automatic model_edge(input int e, input logic s, input logic rn,
                              input logic req, input logic [3:0] a, input logic [7:0] d);
        bit busy;
        if (!rn) begin
            while (clr_q.size() > 0 && clr_q[$] >= e) void'(clr_q.pop_back());
            while (out_q.size() > 0 && out_q[$] >= e) void'(out_q.pop_back());
            while (tap_q.size() > 0 && tap_q[$].obs >= e) void'(tap_q.pop_back());
            while (wr_q.size() > 0 && wr_q[$].obs >= e) void'(wr_q.pop_back());
            idle_from    = e + 1;
            overrun_from = INF;
            last_grant   = -10;
            rst_obs      = e;
            seen_rst     = 1;
            return;
        end
        busy = (e < idle_from);
        if (s) begin
            if (busy) begin
                if (overrun_from == INF) overrun_from = e;
            end else begin
                tap_ev_t t;
                clr_q.push_back(e);
                for (int k = 0; k < NUM_PAIRS; k++) begin
                    t.obs = e + 1 + k; t.tap = 4'(k); t.center = (k == NUM_PAIRS - 1);
                    tap_q.push_back(t);
                end
                out_q.push_back(e + NUM_PAIRS + 1);
                idle_from = e + NUM_PAIRS + 3;
            end
        end
        if (req && !busy && !s && last_grant != e - 1) begin
            wr_ev_t w;
            w.obs = e; w.we = (a < NUM_PAIRS); w.addr = a; w.data = d;
            wr_q.push_back(w);
            last_grant = e;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input logic s, input logic rn);
        @(negedge clk);
        if (h_req && bus.oCoefWrAck) h_req = 1'b0;
        bus.iEnSample600k = s;
        rsn               = rn;
        bus.iCoefWrReq    = h_req;
        bus.iCoefWrAddr   = h_addr;
        bus.iCoefWrData   = h_data;
        model_edge(cyc + 1, s, rn, h_req, h_addr, h_data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1);
    endtask

    task automatic start_write(input logic [3:0] a, input logic [7:0] d);
        h_req = 1'b1; h_addr = a; h_data = d;
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (seen_rst) begin
                int  c;
                bit  p;
                c = cyc;
                if (c == rst_obs)
                    chk("reset_zero", 32'({bus.oCoefWrAck, bus.oCoefWe, bus.oCoefWrAddr,
                        bus.oCoefWrData, bus.oCoefRdEn, bus.oTapSel, bus.oCenter, bus.oAccClr,
                        bus.oAccEn, bus.oOutValid, bus.oBusy, bus.oOverrun, bus.oDbgState}), 32'd0);

                while (clr_q.size() > 0 && clr_q[0] < c) void'(clr_q.pop_front());
                p = (clr_q.size() > 0 && clr_q[0] == c);
                chk("acc_clr", 32'(bus.oAccClr), 32'(p));
                if (p) void'(clr_q.pop_front());

                while (tap_q.size() > 0 && tap_q[0].obs < c) void'(tap_q.pop_front());
                p = (tap_q.size() > 0 && tap_q[0].obs == c);
                chk("acc_en", 32'(bus.oAccEn), 32'(p));
                chk("rd_en", 32'(bus.oCoefRdEn), 32'(p));
                if (p) begin
                    tap_ev_t t;
                    t = tap_q.pop_front();
                    chk("tap_sel", 32'(bus.oTapSel), 32'(t.tap));
                    chk("center", 32'(bus.oCenter), 32'(t.center));
                end else begin
                    chk("center_idle", 32'(bus.oCenter), 32'd0);
                end

                while (out_q.size() > 0 && out_q[0] < c) void'(out_q.pop_front());
                p = (out_q.size() > 0 && out_q[0] == c);
                chk("out_valid", 32'(bus.oOutValid), 32'(p));
                if (p) void'(out_q.pop_front());

                while (wr_q.size() > 0 && wr_q[0].obs < c) void'(wr_q.pop_front());
                p = (wr_q.size() > 0 && wr_q[0].obs == c);
                chk("wr_ack", 32'(bus.oCoefWrAck), 32'(p));
                if (p) begin
                    wr_ev_t w;
                    w = wr_q.pop_front();
                    chk("coef_we", 32'(bus.oCoefWe), 32'(w.we));
                    chk("wr_addr", 32'(bus.oCoefWrAddr), 32'(w.addr));
                    chk("wr_data", {24'd0, bus.oCoefWrData}, {24'd0, w.data});
                end else begin
                    chk("coef_we_idle", 32'(bus.oCoefWe), 32'd0);
                end

                chk("busy", 32'(bus.oBusy), 32'(c + 1 < idle_from));
                chk("overrun", 32'(bus.oOverrun), 32'(c >= overrun_from));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.iEnSample600k = 1'b0;
        bus.iCoefWrReq    = 1'b0;
        bus.iCoefWrAddr   = '0;
        bus.iCoefWrData   = '0;

        // reset, then a single sequence
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        idle(3);
        tick(1'b1, 1'b1);
        idle(20);

        // ten samples on the nominal 20-clock period
        for (int n = 0; n < 10; n++) begin
            tick(1'b1, 1'b1);
            idle(19);
        end

        // strobe during a sequence sets the sticky overrun flag
        tick(1'b1, 1'b1);
        idle(4);
        tick(1'b1, 1'b1);
        idle(30);
        tick(1'b0, 1'b0);
        idle(3);

        // idle write, then a write that collides with a strobe
        start_write(4'd3, 8'hFB);
        idle(4);
        start_write(4'd5, 8'h7F);
        tick(1'b1, 1'b1);
        idle(20);

        // write held through a run, and an out-of-range address
        tick(1'b1, 1'b1);
        idle(2);
        start_write(4'd7, 8'h80);
        idle(18);
        start_write(4'd12, 8'h11);
        idle(4);

        // reset in the middle of a run, then a clean sequence
        tick(1'b1, 1'b1);
        idle(6);
        tick(1'b0, 1'b0);
        idle(3);
        tick(1'b1, 1'b1);
        idle(20);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if (!h_req && !bus.oCoefWrAck && $urandom_range(0, 7) == 0)
                start_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            tick(1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 299) != 0));
        end
        idle(30);

        chk("queues_drained", 32'(clr_q.size() + out_q.size() + tap_q.size() + wr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
